// File: rtl/fft_pkg.sv
// Shared encodings for the DIT FFT sequencer: external phase codes seen by the
// address generator, internal FSM states, and the default transform size.
package fft_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int N              = 1 << ADDR_WIDTH_DEF;

  localparam logic [1:0] ST_LOAD   = 2'b00;
  localparam logic [1:0] ST_COMP   = 2'b01;
  localparam logic [1:0] ST_UNLOAD = 2'b10;
  localparam logic [1:0] ST_IDLE   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_UNLOAD
  } fsm_t;

  // COMP and DRAIN look identical to the address generator.
  function automatic logic [1:0] ext_state(input fsm_t s);
    case (s)
      S_LOAD:           return ST_LOAD;
      S_COMP, S_DRAIN:  return ST_COMP;
      S_UNLOAD:         return ST_UNLOAD;
      default:          return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/delay_line.sv
// Enabled shift register: q is d from DEPTH enabled cycles earlier.
// No backpressure; contents freeze while en is low and clear on async reset.
module delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// Phase sequencer for the shared-butterfly DIT FFT: load, ADDR_WIDTH compute+drain sweeps, unload.
// Compute takes ADDR_WIDTH*(N+PIPE_LAT) cycles; load stalls on in_valid, unload holds on !out_ready.
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int PIPE_LAT   = 3,
  localparam int SW        = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [1:0]            state,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  count_over,
  output logic [SW-1:0]         stage,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [SW-1:0]         LAST_STAGE = SW'(ADDR_WIDTH - 1);
  localparam logic [DW-1:0]         DRAIN_MAX  = DW'(PIPE_LAT - 1);

  fsm_t          fsm;
  logic [DW-1:0] drain_cnt;
  logic          rd_done;
  logic          dl_q;
  logic          cd_active;
  logic          load_acc;
  logic          unload_adv;
  logic          cnt_adv;

  assign cd_active  = (fsm == S_COMP) || (fsm == S_DRAIN);
  assign load_acc   = (fsm == S_LOAD) && in_valid;
  // Once sample N-1 has been read, only the output handshake remains.
  assign unload_adv = (fsm == S_UNLOAD) && !rd_done && (!out_valid || out_ready);
  assign cnt_adv    = load_acc || (fsm == S_COMP) || unload_adv;

  assign count_over = cnt_adv && (count == CNT_MAX);
  assign mem_rd_en  = (fsm == S_COMP) || unload_adv;
  assign mem_wr_en  = load_acc || (cd_active && dl_q);
  assign in_ready   = (fsm == S_LOAD);
  assign busy       = (fsm != S_IDLE);
  assign state      = ext_state(fsm);

  delay_line #(
    .WIDTH (1),
    .DEPTH (PIPE_LAT)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .en  (cd_active),
    .d   (mem_rd_en),
    .q   (dl_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= S_IDLE;
      count     <= '0;
      stage     <= '0;
      drain_cnt <= '0;
      rd_done   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        S_IDLE: begin
          count <= '0;
          stage <= '0;
          if (start) fsm <= S_LOAD;
        end
        S_LOAD: begin
          if (in_valid) begin
            if (count == CNT_MAX) begin
              count <= '0;
              fsm   <= S_COMP;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_COMP: begin
          if (count == CNT_MAX) begin
            count     <= '0;
            drain_cnt <= '0;
            fsm       <= S_DRAIN;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_MAX) begin
            drain_cnt <= '0;
            if (stage == LAST_STAGE) begin
              rd_done <= 1'b0;
              fsm     <= S_UNLOAD;
            end else begin
              stage <= stage + 1'b1;
              fsm   <= S_COMP;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_UNLOAD: begin
          if (unload_adv) begin
            out_valid <= 1'b1;
            out_last  <= (count == CNT_MAX);
            if (count == CNT_MAX) rd_done <= 1'b1;
            else                  count   <= count + 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
          if (out_valid && out_ready && out_last) begin
            done      <= 1'b1;
            count     <= '0;
            stage     <= '0;
            rd_done   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            fsm       <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl with N=8, PIPE_LAT=3: load table, compute sweep, unload, abort.
module tb_fft_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] state;
  logic [2:0] count;
  logic       count_over;
  logic [1:0] stage;
  logic       mem_rd_en;
  logic       mem_wr_en;

  int n_chk;
  int n_fail;

  fft_seq_ctrl #(
    .ADDR_WIDTH (3),
    .PIPE_LAT   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .state      (state),
    .count      (count),
    .count_over (count_over),
    .stage      (stage),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       in_valid;
    logic [1:0] exp_state;
    logic [2:0] exp_count;
    logic       exp_co;
    logic       exp_ir;
    logic       exp_wr;
    logic       exp_busy;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Drive just after the rising edge, sample at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " state"}, 32'(state), 32'd3);
    chk({tag, " count"}, 32'(count), 32'd0);
    chk({tag, " stage"}, 32'(stage), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " out_last"}, 32'(out_last), 32'd0);
    chk({tag, " count_over"}, 32'(count_over), 32'd0);
    chk({tag, " rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({tag, " wr_en"}, 32'(mem_wr_en), 32'd0);
  endtask

  initial begin
    int wr_total;
    int hs_total;
    int exp_stage;
    int p;
    int u;

    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;

    // start, in_valid, state, count, count_over, in_ready, wr_en, busy
    vec[0]  = '{1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle: in_valid ignored
    vec[1]  = '{1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0}; // start sampled here
    vec[2]  = '{1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[3]  = '{1'b0, 1'b0, 2'd0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1}; // gap
    vec[4]  = '{1'b1, 1'b1, 2'd0, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1}; // start while busy
    vec[5]  = '{1'b0, 1'b1, 2'd0, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[6]  = '{1'b1, 1'b0, 2'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1}; // gap plus start
    vec[7]  = '{1'b0, 1'b1, 2'd0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[8]  = '{1'b0, 1'b1, 2'd0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 2'd0, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[10] = '{1'b0, 1'b1, 2'd0, 3'd6, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[11] = '{1'b0, 1'b1, 2'd0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1}; // final acceptance

    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      next_cycle();
      start = vec[i].start;
      in_valid = vec[i].in_valid;
      #4;
      chk($sformatf("v%0d state", i), 32'(state), 32'(vec[i].exp_state));
      chk($sformatf("v%0d count", i), 32'(count), 32'(vec[i].exp_count));
      chk($sformatf("v%0d count_over", i), 32'(count_over), 32'(vec[i].exp_co));
      chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vec[i].exp_ir));
      chk($sformatf("v%0d wr_en", i), 32'(mem_wr_en), 32'(vec[i].exp_wr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vec[i].exp_busy));
      chk($sformatf("v%0d rd_en", i), 32'(mem_rd_en), 32'd0);
      chk($sformatf("v%0d stage", i), 32'(stage), 32'd0);
    end

    // Compute sweep: each stage is 8 reads then 3 drain cycles; writes trail reads by 3.
    wr_total = 0;
    for (int c = 0; c < 33; c++) begin
      next_cycle();
      start = (c == 4);
      in_valid = (c < 2);
      #4;
      exp_stage = c / 11;
      p = c % 11;
      chk($sformatf("c%0d state", c), 32'(state), 32'd1);
      chk($sformatf("c%0d stage", c), 32'(stage), 32'(exp_stage));
      chk($sformatf("c%0d count", c), 32'(count), (p < 8) ? 32'(p) : 32'd0);
      chk($sformatf("c%0d rd_en", c), 32'(mem_rd_en), (p < 8) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d count_over", c), 32'(count_over), (p == 7) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d wr_en", c), 32'(mem_wr_en),
          (c >= 3 && ((c - 3) % 11) < 8) ? 32'd1 : 32'd0);
      chk($sformatf("c%0d in_ready", c), 32'(in_ready), 32'd0);
      if (mem_wr_en === 1'b1) wr_total++;
    end
    chk("compute write total", 32'(wr_total), 32'd24);

    // Unload with out_ready toggling 1,0,1,0...
    start = 1'b0;
    in_valid = 1'b0;
    hs_total = 0;
    for (u = 0; u < 17; u++) begin
      next_cycle();
      out_ready = (u % 2 == 0);
      #4;
      chk($sformatf("u%0d state", u), 32'(state), 32'd2);
      chk($sformatf("u%0d out_valid", u), 32'(out_valid), (u >= 1) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d rd_en", u), 32'(mem_rd_en),
          (u % 2 == 0 && u <= 14) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d count", u), 32'(count),
          (u <= 14) ? 32'((u + 1) / 2) : 32'd7);
      chk($sformatf("u%0d count_over", u), 32'(count_over), (u == 14) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d out_last", u), 32'(out_last), (u >= 15) ? 32'd1 : 32'd0);
      chk($sformatf("u%0d wr_en", u), 32'(mem_wr_en), 32'd0);
      chk($sformatf("u%0d done", u), 32'(done), 32'd0);
      if (out_valid === 1'b1 && out_ready === 1'b1) hs_total++;
    end
    chk("unload handshakes", 32'(hs_total), 32'd8);

    next_cycle();
    out_ready = 1'b0;
    #4;
    chk("done pulse", 32'(done), 32'd1);
    chk("done state", 32'(state), 32'd3);
    chk("done busy", 32'(busy), 32'd0);
    chk("done out_valid", 32'(out_valid), 32'd0);
    chk("done count", 32'(count), 32'd0);

    next_cycle();
    start = 1'b1;
    #4;
    chk("done clears", 32'(done), 32'd0);

    // Second transform, aborted by reset in stage 1 at count 5.
    next_cycle();
    start = 1'b0;
    in_valid = 1'b1;
    #4;
    chk("reload state", 32'(state), 32'd0);
    for (int i = 1; i < 8; i++) begin
      next_cycle();
      #4;
    end
    chk("reload final count", 32'(count), 32'd7);
    for (int c = 0; c < 17; c++) begin
      next_cycle();
      in_valid = 1'b0;
      #4;
    end
    chk("abort point stage", 32'(stage), 32'd1);
    chk("abort point count", 32'(count), 32'd5);
    chk("abort point wr_en", 32'(mem_wr_en), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      in_valid = 1'b1;
      #4;
      chk($sformatf("post-abort%0d wr_en", i), 32'(mem_wr_en), 32'd0);
      chk($sformatf("post-abort%0d state", i), 32'(state), 32'd3);
      chk($sformatf("post-abort%0d in_ready", i), 32'(in_ready), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
